bullet_collision_hp: RTL and testbench

Downstream consumer of the horizontal/vertical bullet generators. Registers a bounding-box overlap test between the active bullet and the player heart, decrements player HP on each hit, and drives `player_collision` back to the generator, which clears its bullet while it is high. Also provides a timed invulnerability window and a game-over flag for the top-level game FSM.

---
 rtl/bullet_collision_hp.sv | 182 ++++++++++++++++++
 tb/tb_bullet_collision_hp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_collision_hp.sv
// bullet_collision_hp
// Registers the bounding-box overlap between the active bullet and the player,
// takes one HP per counted hit and drives player_collision back to the bullet
// generator so it clears the bullet. Adds a timed invulnerability window after
// each hit. Also flags game over for the top-level game FSM.
//
// Optional feature macro: BULLET_COLLISION_IFRAME_EN
//   defined   : HIT is followed by an INVULN window of IFRAME_CYCLES clocks
//   undefined : no INVULN state or counter; HIT returns straight to ALIVE
//
// Ports
//   CLOCK_50         in   system clock
//   resetn           in   asynchronous active-low reset
//   enable           in   game running; low freezes detection and the FSM
//   restart          in   synchronous pulse; restores HP and returns to ALIVE
//   bullet_x/_y      in   bullet top-left corner (8b x, 7b y)
//   bullet_active    in   bullet valid
//   player_x/_y      in   player top-left corner (8b x, 7b y)
//   player_collision out  high in HIT/INVULN, held high in DEAD
//   hit_pulse        out  one strobe per counted hit
//   hp               out  current HP
//   game_over        out  high in DEAD
module bullet_collision_hp #(
    parameter int unsigned BULLET_W      = 8,
    parameter int unsigned BULLET_H      = 2,
    parameter int unsigned PLAYER_W      = 8,
    parameter int unsigned PLAYER_H      = 8,
    parameter int unsigned MAX_HP        = 5,
    parameter int unsigned IFRAME_CYCLES = 25_000_000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       enable,
    input  logic       restart,
    input  logic [7:0] bullet_x,
    input  logic [6:0] bullet_y,
    input  logic       bullet_active,
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    output logic       player_collision,
    output logic       hit_pulse,
    output logic [3:0] hp,
    output logic       game_over
);

    localparam int unsigned XW   = 9;
    localparam int unsigned YW   = 8;
    localparam int unsigned HP_W = 4;

    localparam logic [1:0] S_ALIVE  = 2'd0;
    localparam logic [1:0] S_HIT    = 2'd1;
    localparam logic [1:0] S_DEAD   = 2'd3;
`ifdef BULLET_COLLISION_IFRAME_EN
    localparam logic [1:0] S_INVULN = 2'd2;
    localparam int unsigned CNT_W   = 25;
`endif

    // Reject parameter values outside the supported ranges at elaboration.
    if (IFRAME_CYCLES < 1 || IFRAME_CYCLES > 33554431 ||
        MAX_HP < 1 || MAX_HP > 15) begin : g_param_check
        $error("bullet_collision_hp: parameter out of range");
    end

    logic [XW-1:0] bx_end, px_end;
    logic [YW-1:0] by_end, py_end;
    logic          overlap_c;
    logic          overlap_q;

    logic [1:0]      state_q, state_d;
    logic [HP_W-1:0] hp_d;
    logic            hit_pulse_d;
    logic            player_collision_d;
    logic            game_over_d;
`ifdef BULLET_COLLISION_IFRAME_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Box overlap; sums are widened one bit so boxes near the right/bottom edge never wrap.
    always_comb begin
        bx_end    = XW'(bullet_x) + XW'(BULLET_W);
        px_end    = XW'(player_x) + XW'(PLAYER_W);
        by_end    = YW'(bullet_y) + YW'(BULLET_H);
        py_end    = YW'(player_y) + YW'(PLAYER_H);
        overlap_c = (XW'(bullet_x) < px_end) && (XW'(player_x) < bx_end) &&
                    (YW'(bullet_y) < py_end) && (YW'(player_y) < by_end);
    end

    // Stage 1: registered, gated hit request.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            overlap_q <= 1'b0;
        else if (restart)
            overlap_q <= 1'b0;
        else
            overlap_q <= overlap_c & bullet_active & enable;
    end

    // Stage 2: next-state and next-output logic; everything holds while enable is low.
    always_comb begin
        state_d     = state_q;
        hp_d        = hp;
        hit_pulse_d = hit_pulse;
`ifdef BULLET_COLLISION_IFRAME_EN
        cnt_d       = cnt_q;
`endif
        if (restart) begin
            state_d     = S_ALIVE;
            hp_d        = HP_W'(MAX_HP);
            hit_pulse_d = 1'b0;
`ifdef BULLET_COLLISION_IFRAME_EN
            cnt_d       = '0;
`endif
        end else if (enable) begin
            hit_pulse_d = 1'b0;
            case (state_q)
                S_ALIVE: begin
                    if (overlap_q && (hp != '0)) begin
                        hp_d        = hp - HP_W'(1);
                        hit_pulse_d = 1'b1;
                        state_d     = S_HIT;
                    end
                end
                S_HIT: begin
                    if (hp == '0) begin
                        state_d = S_DEAD;
                    end else begin
`ifdef BULLET_COLLISION_IFRAME_EN
                        cnt_d   = CNT_W'(IFRAME_CYCLES - 1);
                        state_d = S_INVULN;
`else
                        state_d = S_ALIVE;
`endif
                    end
                end
`ifdef BULLET_COLLISION_IFRAME_EN
                S_INVULN: begin
                    if (cnt_q == '0)
                        state_d = S_ALIVE;
                    else
                        cnt_d = cnt_q - CNT_W'(1);
                end
`endif
                S_DEAD: begin
                    state_d = S_DEAD;
                end
                default: begin
                    state_d = S_ALIVE;
                end
            endcase
        end
        player_collision_d = (state_d != S_ALIVE);
        game_over_d        = (state_d == S_DEAD);
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q          <= S_ALIVE;
            hp               <= HP_W'(MAX_HP);
            hit_pulse        <= 1'b0;
            player_collision <= 1'b0;
            game_over        <= 1'b0;
        end else begin
            state_q          <= state_d;
            hp               <= hp_d;
            hit_pulse        <= hit_pulse_d;
            player_collision <= player_collision_d;
            game_over        <= game_over_d;
        end
    end

`ifdef BULLET_COLLISION_IFRAME_EN
    // Invulnerability countdown.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_bullet_collision_hp.sv
// Testbench for bullet_collision_hp: directed scenarios plus randomized play,
// checked against a behavioural HP/collision-window model and a hit scoreboard.
module tb_bullet_collision_hp;

    localparam int IFRAME = 4;
    localparam int MAXHP  = 3;
    localparam int BW = 8, BH = 2, PW = 8, PH = 8;

    logic       CLOCK_50 = 1'b0;
    logic       resetn, enable, restart, bullet_active;
    logic [7:0] bullet_x, player_x;
    logic [6:0] bullet_y, player_y;
    logic       player_collision, hit_pulse, game_over;
    logic [3:0] hp;

    int n_cmp = 0;
    int n_err = 0;
    int exp_hits[$];

    // Behavioural model state
    bit m_ovq, m_pulse, m_coll, m_dead;
    int m_hp, m_win;

    bullet_collision_hp #(
        .BULLET_W(BW), .BULLET_H(BH), .PLAYER_W(PW), .PLAYER_H(PH),
        .MAX_HP(MAXHP), .IFRAME_CYCLES(IFRAME)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable), .restart(restart),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
        .player_x(player_x), .player_y(player_y),
        .player_collision(player_collision), .hit_pulse(hit_pulse),
        .hp(hp), .game_over(game_over)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit boxes_overlap(input int bx, input int by, input int px, input int py);
        return (bx < px + PW) && (px < bx + BW) && (by < py + PH) && (py < by + BH);
    endfunction

    task automatic model_reset();
        m_ovq = 0; m_pulse = 0; m_coll = 0; m_dead = 0;
        m_hp = MAXHP; m_win = 0;
        exp_hits.delete();
    endtask

    // One clock of the model, using the inputs present at this edge.
    task automatic model_step();
        bit old_ov;
        bit ov_now;
        ov_now = boxes_overlap(int'(bullet_x), int'(bullet_y), int'(player_x), int'(player_y))
                 && bullet_active;
        if (restart) begin
            model_reset();
        end else if (!enable) begin
            m_ovq = 0;
        end else begin
            old_ov = m_ovq;
            m_ovq  = ov_now;
            if (m_dead) begin
                m_pulse = 0;
            end else if (m_pulse) begin
                m_pulse = 0;
                if (m_hp == 0) begin
                    m_dead = 1;
                end else begin
`ifdef BULLET_COLLISION_IFRAME_EN
                    m_win = IFRAME;
`else
                    m_coll = 0;
`endif
                end
            end else if (m_win > 0) begin
                m_win--;
                if (m_win == 0) m_coll = 0;
            end else if (old_ov && m_hp > 0) begin
                m_hp--;
                m_pulse = 1;
                m_coll  = 1;
                exp_hits.push_back(m_hp);
            end
        end
    endtask

    task automatic check_outputs();
        check("hp", int'(hp), m_hp);
        check("hit_pulse", int'(hit_pulse), int'(m_pulse));
        check("player_collision", int'(player_collision), int'(m_coll));
        check("game_over", int'(game_over), int'(m_dead));
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        check_outputs();
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_bullet(input int bx, input int by, input bit act);
        bullet_x = 8'(bx);
        bullet_y = 7'(by);
        bullet_active = act;
    endtask

    // Scoreboard monitor: each new hit strobe must match the next expected hit.
    bit prev_pulse = 1'b0;
    always @(negedge CLOCK_50) begin
        if (hit_pulse && !prev_pulse) begin
            int e;
            n_cmp++;
            if (exp_hits.size() == 0) begin
                n_err++;
                $display("FAIL hit_event: unexpected hit_pulse with hp=%0d, none expected at %0t", hp, $time);
            end else begin
                e = exp_hits.pop_front();
                if (int'(hp) != e) begin
                    n_err++;
                    $display("FAIL hit_event_hp: got %0d expected %0d at %0t", hp, e, $time);
                end
            end
        end
        prev_pulse = hit_pulse;
    end

    initial begin
        resetn = 1'b0; enable = 1'b1; restart = 1'b0;
        player_x = 8'd74; player_y = 7'd68;
        set_bullet(0, 0, 0);
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        check("reset_hp", int'(hp), 3);
        check("reset_collision", int'(player_collision), 0);
        check("reset_hit_pulse", int'(hit_pulse), 0);
        check("reset_game_over", int'(game_over), 0);
        resetn = 1'b1;
        cycles(2);

        // Held overlap: first hit two clocks after apply, then repeat hits to death
        set_bullet(70, 71, 1);
        cycles(2);
        check("first_hit_pulse", int'(hit_pulse), 1);
        check("first_hit_hp", int'(hp), 2);
        cycles(18);
        check("dead_hp", int'(hp), 0);
        check("dead_game_over", int'(game_over), 1);
        restart = 1'b1;
        set_bullet(70, 71, 0);
        cycle();
        restart = 1'b0;
        check("restart_hp", int'(hp), 3);
        check("restart_game_over", int'(game_over), 0);
        cycles(3);

        // Right-edge boundary
        set_bullet(66, 71, 1);
        cycles(6);
        check("edge_x66_no_hit", int'(hp), 3);
        set_bullet(67, 71, 1);
        cycles(2);
        check("edge_x67_hit", int'(hp), 2);
        set_bullet(67, 71, 0);
        cycles(12);

        // Enable freeze in the middle of the invulnerability window
        restart = 1'b1; cycle(); restart = 1'b0;
        set_bullet(70, 71, 1);
        cycles(2);
        set_bullet(70, 71, 0);
        cycles(2);
        enable = 1'b0;
        cycles(10);
        enable = 1'b1;
        cycles(10);

        // Restart coincident with a registered hit request
        set_bullet(70, 71, 1);
        cycle();
        restart = 1'b1;
        set_bullet(70, 71, 0);
        cycle();
        restart = 1'b0;
        check("restart_vs_hit_hp", int'(hp), 3);
        check("restart_vs_hit_pulse", int'(hit_pulse), 0);
        cycles(3);

        // Asynchronous reset mid-window
        set_bullet(70, 71, 1);
        cycles(3);
        set_bullet(70, 71, 0);
        cycle();
        #2 resetn = 1'b0;
        #1 model_reset();
        check("async_reset_hp", int'(hp), 3);
        check("async_reset_collision", int'(player_collision), 0);
        check("async_reset_hit_pulse", int'(hit_pulse), 0);
        check("async_reset_game_over", int'(game_over), 0);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        cycles(2);

        // Randomized play around the player
        for (int i = 0; i < 3000; i++) begin
            int px, py, bx, by;
            if (i % 200 == 0) begin
                player_x = 8'($urandom_range(20, 230));
                player_y = 7'($urandom_range(12, 110));
            end
            px = int'(player_x);
            py = int'(player_y);
            bx = px - 12 + int'($urandom_range(0, 24));
            by = py - 10 + int'($urandom_range(0, 20));
            set_bullet(bx, by, $urandom_range(0, 9) != 0);
            enable  = ($urandom_range(0, 15) != 0);
            restart = ($urandom_range(0, 99) == 0);
            cycle();
        end
        restart = 1'b0; enable = 1'b1;
        set_bullet(0, 0, 0);
        cycles(3);
        check("scoreboard_drained", exp_hits.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
